// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage-register state encoding and the packed
// payload layouts carried between CPU pipeline stages.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int XLEN = 32;

  // Stage boundary payload widths
  localparam int IFID_DATA_W  = 64;   // pc + instruction
  localparam int IDEXE_DATA_W = 128;
  localparam int EXMEM_DATA_W = 112;

  // MEM/WB payload layout, LSB first
  localparam int MEMWB_RV16_OFS      = 0;
  localparam int MEMWB_RV16_W        = 1;
  localparam int MEMWB_EXC_VALID_OFS = MEMWB_RV16_OFS + MEMWB_RV16_W;
  localparam int MEMWB_EXC_VALID_W   = 1;
  localparam int MEMWB_EXC_CAUSE_OFS = MEMWB_EXC_VALID_OFS + MEMWB_EXC_VALID_W;
  localparam int MEMWB_EXC_CAUSE_W   = 5;
  localparam int MEMWB_CSR_WE_OFS    = MEMWB_EXC_CAUSE_OFS + MEMWB_EXC_CAUSE_W;
  localparam int MEMWB_CSR_WE_W      = 1;
  localparam int MEMWB_CSR_ADDR_OFS  = MEMWB_CSR_WE_OFS + MEMWB_CSR_WE_W;
  localparam int MEMWB_CSR_ADDR_W    = 12;
  localparam int MEMWB_CSR_WDATA_OFS = MEMWB_CSR_ADDR_OFS + MEMWB_CSR_ADDR_W;
  localparam int MEMWB_CSR_WDATA_W   = XLEN;
  localparam int MEMWB_WDATA_OFS     = MEMWB_CSR_WDATA_OFS + MEMWB_CSR_WDATA_W;
  localparam int MEMWB_WDATA_W       = XLEN;
  localparam int MEMWB_REGINDEX_OFS  = MEMWB_WDATA_OFS + MEMWB_WDATA_W;
  localparam int MEMWB_REGINDEX_W    = 5;
  localparam int MEMWB_WR_REG_OFS    = MEMWB_REGINDEX_OFS + MEMWB_REGINDEX_W;
  localparam int MEMWB_WR_REG_W      = 1;
  localparam int MEMWB_DATA_W        = MEMWB_WR_REG_OFS + MEMWB_WR_REG_W;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment unless already at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, clear wins over increment
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, optional skid entry,
// flush/hold control, free-running sideband and a bubble counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, dn_data reads as zero (NOP)
// ST_ONE   | main entry valid
// ST_TWO   | main + skid entries valid (SKID=1 only)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SIDE_W = 32,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              cpurst,
  input  logic              flush,
  input  logic              hold,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  input  logic [SIDE_W-1:0] side_in,
  output logic [SIDE_W-1:0] side_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic              push, pop, bubble;

  // Acceptance: single-entry mode passes dn_ready straight through to up_ready
  always_comb begin
    up_ready = 1'b0;
    if (!flush && !hold) begin
      if (SKID != 0) up_ready = (state_q != ST_TWO);
      else           up_ready = (state_q == ST_EMPTY) || dn_ready;
    end
  end

  assign dn_valid = (state_q != ST_EMPTY) && !hold;
  assign push     = up_valid && up_ready;
  // Downstream must ignore the entry during flush, so it is not consumed
  assign pop      = dn_valid && dn_ready && !flush;
  assign bubble   = !dn_valid;

  // Next state and entry contents; flush kills, hold freezes
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    side_d  = side_in;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (!hold) begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = up_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = up_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end else if (push) begin
            state_d = ST_TWO;
            skid_d  = up_data;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State, entry and sideband registers
  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      side_q  <= side_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (cpurst),
    .inc (bubble),
    .cnt (bubble_cnt)
  );

  assign dn_data   = main_q;
  assign side_out  = side_q;
  assign occupancy = state_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register for the CPU pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries one packed payload bus plus a free-running sideband bus (e.g. PC).
- Adds a valid/ready handshake, an optional 2-entry skid buffer, and a split between flush (kill contents) and hold (freeze, output bubble).
- Provides a saturating bubble counter for pipeline-efficiency measurement.

Parameters:
- DATA_W, 64: payload width; packed control+data fields of the stage.
- SIDE_W, 32: sideband width; captured every cycle, outside the handshake.
- SKID, 0: 0 = single entry (combinational ready path); 1 = two entries (ready depends only on internal state and hold).
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  clock
- cpurst  in  1  synchronous active-high reset
- flush  in  1  kill all held entries (exception, interrupt, branch redirect)
- hold  in  1  freeze stage; downstream sees a bubble
- up_valid  in  1  upstream offers an entry
- up_ready  out  1  stage accepts an entry this cycle
- up_data  in  DATA_W  upstream payload
- dn_valid  out  1  stage presents an entry
- dn_ready  in  1  downstream consumes the entry
- dn_data  out  DATA_W  payload presented downstream
- side_in  in  SIDE_W  sideband input
- side_out  out  SIDE_W  sideband registered one cycle
- occupancy  out  2  number of held entries (0..2)
- bubble_cnt  out  CNT_W  count of cycles with dn_valid=0

Behaviour:
- One clock (clk). Reset cpurst is synchronous and active-high.
- Priority order: cpurst > flush > hold > normal operation.
- Transfers: push = up_valid & up_ready; pop = dn_valid & dn_ready.

Reset (cpurst=1 at a clk edge):
- State goes to EMPTY; all entry registers, side_out and bubble_cnt become 0.
- Next cycle: dn_valid=0, dn_data=0, occupancy=0.
- Reset mid-transfer discards the entry with no partial state.

States:
- EMPTY: occupancy 0.
- ONE: main entry valid.
- TWO: main and skid entries valid. Reachable only with SKID=1.

up_ready:
- SKID=0: ~flush & ~hold & (state==EMPTY | dn_ready).
- SKID=1: ~flush & ~hold & (state!=TWO).

Outputs:
- dn_valid = (state!=EMPTY) & ~hold.
- dn_data = main entry. It is zero whenever state==EMPTY, so zero-decoded fields read as a NOP.

Transitions (flush=0, hold=0):
- EMPTY + push -> ONE; main <= up_data.
- ONE + push & pop -> ONE; main <= up_data.
- ONE + pop only -> EMPTY; main <= 0.
- ONE + push only -> TWO (SKID=1); skid <= up_data.
- TWO + pop -> ONE; main <= skid, skid <= 0. There is no push in TWO.
- No push and no pop: state holds.

Flush:
- Next state EMPTY; main and skid <= 0.
- An offered up_data is dropped (up_ready=0 that cycle).
- dn_valid in the flush cycle still reflects the current state, but pop is ignored. Downstream must gate on flush itself.

Hold:
- State and entries are frozen; up_ready=0; dn_valid forced 0 combinationally.
- dn_data stays stable, so no entry is lost or duplicated.
- flush=1 together with hold=1 behaves as flush.

Sideband:
- side_out <= side_in on every clk edge unless cpurst.
- Unaffected by flush, hold and the handshake.

Latency:
- up_data appears on dn_data one cycle after push (from EMPTY, or from ONE with a simultaneous pop).
- Throughput is 1 entry per cycle when dn_ready=1.

bubble_cnt:
- +1 on each edge where the presented dn_valid=0 (including hold cycles).
- Saturates at 2^CNT_W-1.
- Cleared only by cpurst.

occupancy: 0/1/2 for EMPTY/ONE/TWO, registered.

Decomposition:
- Shared pipeline package holds:
  - state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2);
  - per-stage DATA_W constants and field offsets for the packed payloads of MEM/WB (wr_reg, regindex, wdata, csr fields, exception fields, rv16).
- One sub-module: sat_counter (CNT_W-wide saturating incrementer with synchronous clear), used for bubble_cnt.
- Control FSM and entry registers stay inline.

Test Plan:
- cpurst held 2 cycles mid-stream (SKID=1, TWO) -> next cycle occupancy=0, dn_valid=0, dn_data=0, side_out=0, bubble_cnt=0.
- SKID=0, dn_ready=1, up_valid=1 with up_data=0x1,0x2,0x3 on consecutive cycles -> dn_data=0x1,0x2,0x3 one cycle later each; up_ready stays 1; bubble_cnt stays flat.
- SKID=1, dn_ready=0, push 0xA then 0xB -> occupancy=2, up_ready=0; then dn_ready=1 -> dn_data=0xA, then 0xB, then occupancy=0.
- State ONE holding 0x55, hold=1 for 3 cycles -> dn_valid=0 for 3 cycles, dn_data=0x55 throughout, up_ready=0, bubble_cnt +3; after hold drops, 0x55 is delivered exactly once.
- State TWO, flush=1 with up_valid=1, up_data=0x77 -> next cycle occupancy=0, dn_data=0; 0x77 never appears.
- flush=1 and hold=1 together -> flush semantics; side_in=0x1000 captured to side_out on the same edge regardless.
- CNT_W=4, 20 idle cycles -> bubble_cnt saturates at 15.
